// File: rtl/binary_search_guess8_if.sv
// Handshake bundle between the binary-search engine and its controller/comparator.
// The slave side is the engine; the master side starts searches and returns compare codes.
interface binary_search_guess8_if;
  logic       iStart;
  logic [2:0] iCmp;
  logic [7:0] oGuess;
  logic       oBusy;
  logic       oDone;
  logic       oErr;
  logic [3:0] oSteps;

  modport master (
    output iStart,
    output iCmp,
    input  oGuess,
    input  oBusy,
    input  oDone,
    input  oErr,
    input  oSteps
  );

  modport slave (
    input  iStart,
    input  iCmp,
    output oGuess,
    output oBusy,
    output oDone,
    output oErr,
    output oSteps
  );
endinterface

// File: rtl/binary_search_guess8.sv
// 8-bit binary-search engine: drives candidate guesses into an external
// combinational comparator and narrows [lo, hi] until the answer is "equal".
// Inconsistent or malformed comparator answers park the engine in ERR.
module binary_search_guess8 (
  input  logic                         clk,
  input  logic                         rst_n,
  binary_search_guess8_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } stateT;

  localparam logic [2:0] CMP_ABOVE = 3'b100;
  localparam logic [2:0] CMP_BELOW = 3'b010;
  localparam logic [2:0] CMP_EQUAL = 3'b001;

  stateT      stateReg, stateNext;
  logic [7:0] loReg, loNext;
  logic [7:0] hiReg, hiNext;
  logic [7:0] guessReg, guessNext;
  logic [3:0] stepsReg, stepsNext;

  // Midpoint sums are formed 9 bits wide so lo+hi can never wrap.
  logic [8:0] sumAbove;
  logic [8:0] sumBelow;

  // Candidate midpoints for the two narrowing directions.
  always_comb begin
    sumAbove = {1'b0, guessReg} + 9'd1 + {1'b0, hiReg};
    sumBelow = {1'b0, loReg} + {1'b0, guessReg} - 9'd1;
  end

  // State and datapath registers; reset forces the idle, zeroed-guess state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      loReg    <= 8'd0;
      hiReg    <= 8'd255;
      guessReg <= 8'd0;
      stepsReg <= 4'd0;
    end else begin
      stateReg <= stateNext;
      loReg    <= loNext;
      hiReg    <= hiNext;
      guessReg <= guessNext;
      stepsReg <= stepsNext;
    end
  end

  // Next-state and datapath update: start handling, compare consumption, error detection.
  always_comb begin
    stateNext = stateReg;
    loNext    = loReg;
    hiNext    = hiReg;
    guessNext = guessReg;
    stepsNext = stepsReg;

    case (stateReg)
      SEARCH: begin
        // Every sampled compare counts, including the one that ends the search.
        stepsNext = stepsReg + 4'd1;
        case (bus.iCmp)
          CMP_EQUAL: begin
            stateNext = DONE;
          end
          CMP_ABOVE: begin
            // guess==hi means no room above: inconsistent answer, also avoids 255 wrap.
            if (guessReg == hiReg) begin
              stateNext = ERR;
            end else begin
              loNext    = guessReg + 8'd1;
              guessNext = sumAbove[8:1];
            end
          end
          CMP_BELOW: begin
            // guess==lo means no room below: inconsistent answer, also avoids 0 wrap.
            if (guessReg == loReg) begin
              stateNext = ERR;
            end else begin
              hiNext    = guessReg - 8'd1;
              guessNext = sumBelow[8:1];
            end
          end
          default: begin
            stateNext = ERR;
          end
        endcase
      end
      default: begin
        // IDLE, DONE and ERR all hold their results until a new start.
        if (bus.iStart) begin
          stateNext = SEARCH;
          loNext    = 8'd0;
          hiNext    = 8'd255;
          guessNext = 8'd127;
          stepsNext = 4'd0;
        end
      end
    endcase
  end

  // Status flags decode straight from the state register.
  always_comb begin
    bus.oGuess = guessReg;
    bus.oSteps = stepsReg;
    bus.oBusy  = (stateReg == SEARCH);
    bus.oDone  = (stateReg == DONE);
    bus.oErr   = (stateReg == ERR);
  end

endmodule

// File: tb/tb_binary_search_guess8.sv
// Self-checking bench for binary_search_guess8: a behavioural comparator closes
// the loop, and expected end-of-search results flow through a scoreboard queue.
module tb_binary_search_guess8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  binary_search_guess8_if bus();

  logic [7:0] tgt;
  logic       forceEn;
  logic [2:0] forceVal;

  // Behavioural DataCompare8: a = target, b = guess, code {a>b, a<b, a==b}.
  assign bus.iCmp = forceEn ? forceVal :
                    (tgt > bus.oGuess) ? 3'b100 :
                    (tgt < bus.oGuess) ? 3'b010 : 3'b001;

  binary_search_guess8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] guess;
    logic [3:0] steps;
    logic       done;
    logic       err;
  } expT;

  expT expQ[$];

  // Reference search; mode 1 models a comparator that always answers "above".
  function automatic expT modelSearch(input int t, input int mode);
    int lo = 0;
    int hi = 255;
    int g;
    int n = 0;
    expT e;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      g = (lo + hi) / 2;
      n++;
      if (mode == 0 && g == t) begin
        e.done = 1'b1; e.guess = g[7:0]; e.steps = n[3:0];
        return e;
      end
      if (mode == 1 || t > g) begin
        if (g == hi) begin
          e.err = 1'b1; e.guess = g[7:0]; e.steps = n[3:0];
          return e;
        end
        lo = g + 1;
      end else begin
        if (g == lo) begin
          e.err = 1'b1; e.guess = g[7:0]; e.steps = n[3:0];
          return e;
        end
        hi = g - 1;
      end
    end
    return e;
  endfunction

  // Called at a negedge; one-cycle start pulse, returns at the following negedge.
  task automatic startPulse();
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
  endtask

  // Advance negedge by negedge while busy, bounded to catch a hung search.
  task automatic waitEnd(output int cyc, output bit timedOut);
    cyc = 0;
    timedOut = 1'b0;
    while (bus.oBusy) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20) begin
        timedOut = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b guess=%0d steps=%0d want all 0",
               bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs idle");
  endtask

  task automatic test_single();
    int cyc; bit to; expT e;
    tgt = 8'd127; forceEn = 1'b0;
    expQ.push_back(modelSearch(127, 0));
    startPulse();
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oGuess !== 8'd127) begin
      errors++;
      $display("FAIL single_start got busy=%b guess=%0d want busy=1 guess=127", bus.oBusy, bus.oGuess);
    end
    waitEnd(cyc, to);
    e = expQ.pop_front();
    checks++;
    if (to || cyc != int'(e.steps) ||
        {bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps}) begin
      errors++;
      $display("FAIL single_result got cyc=%0d done=%b err=%b guess=%0d steps=%0d want cyc=%0d done=%b guess=%0d steps=%0d",
               cyc, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps, e.steps, e.done, e.guess, e.steps);
    end
    $display("single: target 127 guess=%0d steps=%0d", bus.oGuess, bus.oSteps);
  endtask

  task automatic test_upper();
    logic [7:0] seq [9] = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    expT e;
    tgt = 8'd255;
    expQ.push_back(modelSearch(255, 0));
    startPulse();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus.oBusy !== 1'b1 || bus.oGuess !== seq[i]) begin
        errors++;
        $display("FAIL upper_seq[%0d] got busy=%b guess=%0d want busy=1 guess=%0d", i, bus.oBusy, bus.oGuess, seq[i]);
      end
      @(negedge clk);
    end
    e = expQ.pop_front();
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps} ||
        e.steps !== 4'd9) begin
      errors++;
      $display("FAIL upper_result got done=%b err=%b guess=%0d steps=%0d want done=1 guess=255 steps=9",
               bus.oDone, bus.oErr, bus.oGuess, bus.oSteps);
    end
    $display("upper: target 255 guess=%0d steps=%0d", bus.oGuess, bus.oSteps);
  endtask

  task automatic test_lower();
    logic [7:0] seq [8] = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    expT e;
    tgt = 8'd0;
    expQ.push_back(modelSearch(0, 0));
    startPulse();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.oBusy !== 1'b1 || bus.oGuess !== seq[i]) begin
        errors++;
        $display("FAIL lower_seq[%0d] got busy=%b guess=%0d want busy=1 guess=%0d", i, bus.oBusy, bus.oGuess, seq[i]);
      end
      @(negedge clk);
    end
    e = expQ.pop_front();
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps} ||
        e.steps !== 4'd8) begin
      errors++;
      $display("FAIL lower_result got done=%b err=%b guess=%0d steps=%0d want done=1 guess=0 steps=8",
               bus.oDone, bus.oErr, bus.oGuess, bus.oSteps);
    end
    $display("lower: target 0 guess=%0d steps=%0d", bus.oGuess, bus.oSteps);
  endtask

  // Sweep all targets; each new start is fired in the first DONE cycle.
  task automatic test_back_to_back();
    int cyc; bit to; expT e;
    tgt = 8'd0;
    expQ.push_back(modelSearch(0, 0));
    startPulse();
    for (int t = 0; t < 256; t++) begin
      checks++;
      if (bus.oBusy !== 1'b1 || bus.oGuess !== 8'd127) begin
        errors++;
        $display("FAIL sweep_restart t=%0d got busy=%b guess=%0d want busy=1 guess=127", t, bus.oBusy, bus.oGuess);
      end
      waitEnd(cyc, to);
      e = expQ.pop_front();
      checks++;
      if (to || {bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, 1'b1, 1'b0, t[7:0], e.steps} ||
          bus.oSteps > 4'd9) begin
        errors++;
        $display("FAIL sweep_result t=%0d got done=%b err=%b guess=%0d steps=%0d want done=1 err=0 guess=%0d steps=%0d",
                 t, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps, t, e.steps);
      end
      $display("sweep: target %0d guess=%0d steps=%0d", t, bus.oGuess, bus.oSteps);
      if (t < 255) begin
        tgt = 8'(t + 1);
        expQ.push_back(modelSearch(t + 1, 0));
        startPulse();
      end
    end
  endtask

  task automatic test_errors();
    int cyc; bit to; expT e;
    // Malformed two-hot code on the first compare.
    forceEn = 1'b1; forceVal = 3'b011;
    expQ.push_back('{guess: 8'd127, steps: 4'd1, done: 1'b0, err: 1'b1});
    startPulse();
    waitEnd(cyc, to);
    e = expQ.pop_front();
    checks++;
    if (to || {bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps}) begin
      errors++;
      $display("FAIL err_twohot got done=%b err=%b guess=%0d steps=%0d want err=1 guess=127 steps=1",
               bus.oDone, bus.oErr, bus.oGuess, bus.oSteps);
    end
    $display("errors: code 011 err=%b steps=%0d", bus.oErr, bus.oSteps);
    // Comparator that always says "above": climbs to 255 then trips ERR.
    forceVal = 3'b100;
    expQ.push_back(modelSearch(0, 1));
    startPulse();
    waitEnd(cyc, to);
    e = expQ.pop_front();
    checks++;
    if (to || {bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps} ||
        e.steps !== 4'd9) begin
      errors++;
      $display("FAIL err_always_above got done=%b err=%b guess=%0d steps=%0d want err=1 guess=255 steps=9",
               bus.oDone, bus.oErr, bus.oGuess, bus.oSteps);
    end
    $display("errors: always-above err=%b guess=%0d steps=%0d", bus.oErr, bus.oGuess, bus.oSteps);
    // Clean restart out of ERR.
    @(negedge clk);
    forceEn = 1'b0; tgt = 8'd77;
    expQ.push_back(modelSearch(77, 0));
    startPulse();
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oErr !== 1'b0 || bus.oGuess !== 8'd127 || bus.oSteps !== 4'd0) begin
      errors++;
      $display("FAIL err_restart got busy=%b err=%b guess=%0d steps=%0d want busy=1 err=0 guess=127 steps=0",
               bus.oBusy, bus.oErr, bus.oGuess, bus.oSteps);
    end
    waitEnd(cyc, to);
    e = expQ.pop_front();
    checks++;
    if (to || {bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps}) begin
      errors++;
      $display("FAIL err_restart_result got done=%b err=%b guess=%0d steps=%0d want done=1 guess=77 steps=%0d",
               bus.oDone, bus.oErr, bus.oGuess, bus.oSteps, e.steps);
    end
    $display("errors: restart target 77 guess=%0d steps=%0d", bus.oGuess, bus.oSteps);
  endtask

  // Start held high through the final "equal" compare must not restart the search.
  task automatic test_start_collision();
    expT e;
    tgt = 8'd127;
    expQ.push_back(modelSearch(127, 0));
    bus.iStart = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.iStart = 1'b0;
    @(negedge clk);
    e = expQ.pop_front();
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps}) begin
      errors++;
      $display("FAIL start_collision got busy=%b done=%b guess=%0d steps=%0d want busy=0 done=1 guess=127 steps=1",
               bus.oBusy, bus.oDone, bus.oGuess, bus.oSteps);
    end
    $display("collision: done=%b steps=%0d", bus.oDone, bus.oSteps);
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; expT e;
    tgt = 8'd200;
    startPulse();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oSteps !== 4'd3) begin
      errors++;
      $display("FAIL mid_before_reset got busy=%b steps=%0d want busy=1 steps=3", bus.oBusy, bus.oSteps);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b err=%b guess=%0d steps=%0d want all 0",
               bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oErr} !== 3'b000) begin
      errors++;
      $display("FAIL mid_idle got busy=%b done=%b err=%b want 000", bus.oBusy, bus.oDone, bus.oErr);
    end
    $display("reset_mid: aborted search, idle");
    expQ.push_back(modelSearch(200, 0));
    startPulse();
    // Extra start pulses while busy must be ignored.
    for (int i = 0; i < 2; i++) begin
      bus.iStart = 1'b1;
      @(negedge clk);
      bus.iStart = 1'b0;
    end
    waitEnd(cyc, to);
    e = expQ.pop_front();
    checks++;
    if (to || cyc != int'(e.steps) - 2 ||
        {bus.oBusy, bus.oDone, bus.oErr, bus.oGuess, bus.oSteps} !== {1'b0, e.done, e.err, e.guess, e.steps}) begin
      errors++;
      $display("FAIL mid_research got done=%b err=%b guess=%0d steps=%0d want done=1 guess=200 steps=%0d",
               bus.oDone, bus.oErr, bus.oGuess, bus.oSteps, e.steps);
    end
    $display("reset_mid: target 200 guess=%0d steps=%0d", bus.oGuess, bus.oSteps);
  endtask

  initial begin
    bus.iStart = 1'b0;
    tgt = 8'd0;
    forceEn = 1'b0;
    forceVal = 3'b000;
    test_reset();
    test_single();
    test_upper();
    test_lower();
    test_back_to_back();
    test_errors();
    test_start_collision();
    test_reset_mid();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
